iface_xyz_driver: RTL and testbench
===================================

Name: iface_xyz_driver

Overview:
- Producer end of the three-wire x/y/z interface bundle that the top level currently ties to constant levels (z=0, y=1, x=0) and that leaf modules consume through the hierarchy.
- Accepts 3-bit words on a valid/ready handshake and buffers them in a small FIFO.
- Drives each word onto o_x/o_y/o_z for a programmable number of cycles, then drives the idle level when nothing is pending.
- Instantiated in top in place of the constant ties; its outputs connect to the interface signals.

Parameters:
- DEPTH, 4: FIFO entries. Must be a power of two, 2..16.
- HOLD_CYCLES, 2: cycles each word is held on the bus. Must be 1..255.
- IDLE_XYZ, 3'b010: bus value when idle, as {z,y,x}.

Ports:
- i_clk  input  1  single clock; all state on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  3  word to send, {z,y,x}.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  FIFO can accept a word; equals (o_level < DEPTH).
- o_x  output  1  interface x (registered).
- o_y  output  1  interface y (registered).
- o_z  output  1  interface z (registered).
- o_busy  output  1  a word is currently being held on the bus (registered).
- o_level  output  $clog2(DEPTH)+1  FIFO occupancy (registered).

Behaviour:
- One clock (i_clk). Reset i_rst is asynchronous and active-high.
- Reset values: {o_z,o_y,o_x}=IDLE_XYZ, o_busy=0, o_level=0, o_ready=1, FIFO pointers=0, hold counter=0, FSM=IDLE.
- Reset mid-operation: the FIFO is flushed, the held word is dropped and the bus returns to IDLE_XYZ immediately (asynchronously). Nothing is replayed after reset.
- Push: occurs on a rising edge when i_valid && o_ready. The word is written at the write pointer, which wraps modulo DEPTH.
- When the FIFO is full, o_ready=0 and i_valid is ignored. The word is not dropped; the sender keeps it.
- Pop: decided from the pre-edge o_level only, so there is no same-cycle bypass.
- Simultaneous push and pop: o_level is unchanged and both pointers advance.
- FSM state IDLE:
  - o_busy=0 and the bus is IDLE_XYZ.
  - If o_level>0: pop; on the same edge the bus takes the popped word, o_busy=1, hold counter=HOLD_CYCLES-1, and the FSM moves to HOLD.
- FSM state HOLD:
  - o_busy=1 and the bus is stable.
  - If counter>0: decrement.
  - If counter==0 and o_level>0: pop the next word back-to-back (no idle cycle), reload the counter and stay in HOLD.
  - If counter==0 and o_level==0: the bus returns to IDLE_XYZ, o_busy=0, and the FSM moves to IDLE.
- Latency: a word pushed at edge N into an empty, idle block appears on the bus at edge N+1 and is held exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: one word per cycle with no gaps while the FIFO is non-empty.
- Sustained throughput is 1 word per HOLD_CYCLES cycles. The FIFO absorbs bursts of up to DEPTH words.
- Level arithmetic: o_level never exceeds DEPTH and never underflows. Pointer wrap-around uses $clog2(DEPTH) bits.
- i_data changing while i_valid=0 has no effect.

Optional Feature:
- Macro: IFACE_XYZ_STROBE_EN.
- Defined:
  - Adds output port o_stb (1 bit, registered, reset 0).
  - o_stb pulses high for exactly one cycle, coincident with the first cycle of each newly driven word, including back-to-back words.
  - o_stb stays low when the bus returns to idle.
- Not defined: the o_stb port is absent. All other behaviour is identical.

Test Plan:
- Reset check: assert i_rst mid-cycle with no clock edge -> bus=3'b010, o_busy=0, o_level=0, o_ready=1 immediately.
- Single word: HOLD_CYCLES=2; push 3'b101 at edge N -> bus=3'b101 at edges N+1..N+2, back to 3'b010 at edge N+3, o_busy high for exactly 2 cycles.
- Back-to-back burst: push 3'b001, 3'b110, 3'b011 on consecutive edges -> bus shows each word for exactly 2 cycles with no idle gap, then 3'b010; o_level peaks at 2.
- Full FIFO: DEPTH=4, HOLD_CYCLES=8, hold i_valid=1 for 6 cycles with distinct data -> o_ready drops when o_level=4; the stalled word is accepted once the next pop frees an entry; no word is lost or duplicated; pointer wrap is exercised.
- Reset mid-hold: i_rst pulse while the bus holds 3'b111 with o_level=3 -> bus=3'b010, o_level=0; after release the first push is driven normally.
- Strobe, with IFACE_XYZ_STROBE_EN defined and HOLD_CYCLES=1: push 4 words back-to-back -> o_stb high for 4 consecutive cycles aligned with each word; o_stb=0 when idle.

Source files
------------

// File: rtl/iface_xyz_driver.sv
// Producer for the x/y/z interface bundle: FIFO-buffered words, each held on the bus HOLD_CYCLES.
// Optional o_stb first-cycle strobe is enabled by defining IFACE_XYZ_STROBE_EN.
module iface_xyz_driver #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [2:0]  IDLE_XYZ    = 3'b010
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [2:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_x,
  output logic                   o_y,
  output logic                   o_z,
  output logic                   o_busy,
`ifdef IFACE_XYZ_STROBE_EN
  output logic                   o_stb,
`endif
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
  localparam logic [7:0]    HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {StIdle, StHold} state_t;

  logic [2:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_cnt;
  state_t        r_state;
  logic [2:0]    r_xyz;
  logic          r_busy;
  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_head;

  assign o_ready = (r_level < LVL_FULL);
  assign w_push  = i_valid && o_ready;
  assign w_head  = r_mem[r_rptr];
  // Pop only from the pre-edge level, so a word never bypasses the FIFO.
  assign w_pop   = (r_level != '0) && ((r_state == StIdle) || (r_cnt == 8'd0));

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= 8'd0;
      r_state <= StIdle;
      r_xyz   <= IDLE_XYZ;
      r_busy  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_xyz   <= w_head;
            r_busy  <= 1'b1;
            r_cnt   <= HOLD_RELOAD;
            r_state <= StHold;
          end
        end
        StHold: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (w_pop) begin
            r_xyz <= w_head;
            r_cnt <= HOLD_RELOAD;
          end else begin
            r_xyz   <= IDLE_XYZ;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef IFACE_XYZ_STROBE_EN
  logic r_stb;

  // Every pop loads a fresh word onto the bus, so the pop marks its first cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_pop;
    end
  end

  assign o_stb = r_stb;
`endif

  assign o_x     = r_xyz[0];
  assign o_y     = r_xyz[1];
  assign o_z     = r_xyz[2];
  assign o_busy  = r_busy;
  assign o_level = r_level;

endmodule

// File: tb/tb_iface_xyz_driver.sv
// Directed bench for iface_xyz_driver: three instances with HOLD_CYCLES of 2, 8 and 1.
module tb_iface_xyz_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] data;
  logic       valid2, valid8, valid1;
  logic       rdy2, x2, y2, z2, busy2;
  logic       rdy8, x8, y8, z8, busy8;
  logic       rdy1, x1, y1, z1, busy1;
  logic [2:0] lvl2, lvl8, lvl1;
`ifdef IFACE_XYZ_STROBE_EN
  logic       stb2, stb8, stb1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iface_xyz_driver #(.DEPTH(4), .HOLD_CYCLES(2), .IDLE_XYZ(3'b010)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid2), .o_ready(rdy2),
    .o_x(x2), .o_y(y2), .o_z(z2), .o_busy(busy2),
`ifdef IFACE_XYZ_STROBE_EN
    .o_stb(stb2),
`endif
    .o_level(lvl2)
  );

  iface_xyz_driver #(.DEPTH(4), .HOLD_CYCLES(8), .IDLE_XYZ(3'b010)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid8), .o_ready(rdy8),
    .o_x(x8), .o_y(y8), .o_z(z8), .o_busy(busy8),
`ifdef IFACE_XYZ_STROBE_EN
    .o_stb(stb8),
`endif
    .o_level(lvl8)
  );

  iface_xyz_driver #(.DEPTH(4), .HOLD_CYCLES(1), .IDLE_XYZ(3'b010)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid1), .o_ready(rdy1),
    .o_x(x1), .o_y(y1), .o_z(z1), .o_busy(busy1),
`ifdef IFACE_XYZ_STROBE_EN
    .o_stb(stb1),
`endif
    .o_level(lvl1)
  );

  wire [2:0] bus2 = {z2, y2, x2};
  wire [2:0] bus8 = {z8, y8, x8};
  wire [2:0] bus1 = {z1, y1, x1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] burst_w [3]  = '{3'b001, 3'b110, 3'b011};
  logic [2:0] burst_b [8]  = '{3'b010, 3'b001, 3'b001, 3'b110, 3'b110, 3'b011, 3'b011, 3'b010};
  logic [2:0] burst_l [8]  = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
  logic [2:0] full_w  [6]  = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
  logic [2:0] rst_w   [4]  = '{3'b111, 3'b001, 3'b011, 3'b100};
  logic [2:0] h1_w    [4]  = '{3'b100, 3'b011, 3'b101, 3'b001};
  logic [2:0] h1_b    [6]  = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b001, 3'b010};
  logic       h1_s    [6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int  idx;
    logic rdy_pre;
    rst    = 1'b0;
    data   = 3'b000;
    valid2 = 1'b0;
    valid8 = 1'b0;
    valid1 = 1'b0;

    // Asynchronous reset, no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check_eq("rst_bus", 32'(bus2), 32'(3'b010));
    check_eq("rst_busy", 32'(busy2), 32'd0);
    check_eq("rst_level", 32'(lvl2), 32'd0);
    check_eq("rst_ready", 32'(rdy2), 32'd1);
`ifdef IFACE_XYZ_STROBE_EN
    check_eq("rst_stb", 32'(stb2), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Single word on HOLD_CYCLES=2.
    data   = 3'b101;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    check_eq("sw_n_bus", 32'(bus2), 32'(3'b010));
    check_eq("sw_n_level", 32'(lvl2), 32'd1);
    tick();
    check_eq("sw_n1_bus", 32'(bus2), 32'(3'b101));
    check_eq("sw_n1_busy", 32'(busy2), 32'd1);
    check_eq("sw_n1_level", 32'(lvl2), 32'd0);
    tick();
    check_eq("sw_n2_bus", 32'(bus2), 32'(3'b101));
    check_eq("sw_n2_busy", 32'(busy2), 32'd1);
    tick();
    check_eq("sw_n3_bus", 32'(bus2), 32'(3'b010));
    check_eq("sw_n3_busy", 32'(busy2), 32'd0);

    // Back-to-back burst of three words.
    for (int e = 0; e < 8; e++) begin
      if (e < 3) begin
        valid2 = 1'b1;
        data   = burst_w[e];
      end else begin
        valid2 = 1'b0;
      end
      tick();
      check_eq($sformatf("burst_bus_%0d", e), 32'(bus2), 32'(burst_b[e]));
      check_eq($sformatf("burst_lvl_%0d", e), 32'(lvl2), 32'(burst_l[e]));
    end

    // Data changes without valid are ignored.
    for (int i = 0; i < 3; i++) begin
      data = 3'(i + 4);
      tick();
      check_eq($sformatf("novalid_lvl_%0d", i), 32'(lvl2), 32'd0);
      check_eq($sformatf("novalid_bus_%0d", i), 32'(bus2), 32'(3'b010));
    end

    // Full FIFO on HOLD_CYCLES=8: sender holds each word until accepted.
    idx = 0;
    for (int e = 0; e < 50; e++) begin
      if (idx < 6) begin
        valid8 = 1'b1;
        data   = full_w[idx];
      end else begin
        valid8 = 1'b0;
      end
      rdy_pre = rdy8;
      tick();
      if (valid8 && rdy_pre) idx++;
      if (e == 4) begin
        check_eq("full_e4_ready", 32'(rdy8), 32'd0);
        check_eq("full_e4_level", 32'(lvl8), 32'd4);
      end
      if (e == 8) check_eq("full_e8_ready", 32'(rdy8), 32'd0);
      if (e == 9) begin
        check_eq("full_e9_ready", 32'(rdy8), 32'd1);
        check_eq("full_e9_level", 32'(lvl8), 32'd3);
      end
      if (e == 10) begin
        check_eq("full_e10_level", 32'(lvl8), 32'd4);
        check_eq("full_e10_ready", 32'(rdy8), 32'd0);
        check_eq("full_e10_accepted", 32'(idx), 32'd6);
      end
      if (e >= 1 && e <= 41 && ((e - 1) % 8) == 0)
        check_eq($sformatf("full_first_%0d", e), 32'(bus8), 32'(full_w[(e - 1) / 8]));
      if (e >= 8 && e <= 48 && (e % 8) == 0)
        check_eq($sformatf("full_last_%0d", e), 32'(bus8), 32'(full_w[e / 8 - 1]));
      if (e == 49) begin
        check_eq("full_end_bus", 32'(bus8), 32'(3'b010));
        check_eq("full_end_busy", 32'(busy8), 32'd0);
        check_eq("full_end_level", 32'(lvl8), 32'd0);
      end
    end
    valid8 = 1'b0;

    // Reset while 3'b111 is held with three words queued.
    for (int i = 0; i < 4; i++) begin
      valid8 = 1'b1;
      data   = rst_w[i];
      tick();
    end
    valid8 = 1'b0;
    check_eq("mid_pre_bus", 32'(bus8), 32'(3'b111));
    check_eq("mid_pre_level", 32'(lvl8), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_bus", 32'(bus8), 32'(3'b010));
    check_eq("mid_rst_level", 32'(lvl8), 32'd0);
    check_eq("mid_rst_busy", 32'(busy8), 32'd0);
    check_eq("mid_rst_ready", 32'(rdy8), 32'd1);
    #1 rst = 1'b0;
    data   = 3'b100;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    check_eq("mid_post_level", 32'(lvl8), 32'd1);
    check_eq("mid_post_bus0", 32'(bus8), 32'(3'b010));
    tick();
    check_eq("mid_post_bus1", 32'(bus8), 32'(3'b100));
    check_eq("mid_post_busy", 32'(busy8), 32'd1);

    // HOLD_CYCLES=1: one word per cycle, no gaps.
    for (int e = 0; e < 6; e++) begin
      if (e < 4) begin
        valid1 = 1'b1;
        data   = h1_w[e];
      end else begin
        valid1 = 1'b0;
      end
      tick();
      check_eq($sformatf("h1_bus_%0d", e), 32'(bus1), 32'(h1_b[e]));
      check_eq($sformatf("h1_busy_%0d", e), 32'(busy1), 32'(h1_s[e]));
`ifdef IFACE_XYZ_STROBE_EN
      check_eq($sformatf("h1_stb_%0d", e), 32'(stb1), 32'(h1_s[e]));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
